// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for demux_1_4_stream: one upstream port and N_OUT downstream channels.
// err_cnt_o is present only when DEMUX_ERR_CNT_EN is defined.
`timescale 1ns/1ps
interface demux_1_4_stream_if #(
  parameter int DATA_W = 4,
  parameter int N_OUT  = 4
);
  logic [DATA_W-1:0]       in_data_i;
  logic [N_OUT-1:0]        in_sel_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [N_OUT*DATA_W-1:0] out_data_o;
  logic [N_OUT-1:0]        out_valid_o;
  logic [N_OUT-1:0]        out_ready_i;
  logic                    err_o;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0]              err_cnt_o;
`endif

  modport master (
`ifdef DEMUX_ERR_CNT_EN
    input  err_cnt_o,
`endif
    output in_data_i, in_sel_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, err_o
  );

  modport slave (
`ifdef DEMUX_ERR_CNT_EN
    output err_cnt_o,
`endif
    input  in_data_i, in_sel_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, err_o
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-N_OUT stream demultiplexer with one-hot select and per-channel holding register.
// Optional saturating illegal-select counter enabled by DEMUX_ERR_CNT_EN.
`timescale 1ns/1ps
module demux_1_4_stream #(
  parameter int DATA_W = 4,
  parameter int N_OUT  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  demux_1_4_stream_if.slave  bus
);

  logic [N_OUT-1:0]  vld_p0;
  logic [DATA_W-1:0] data_p0 [N_OUT];
  logic              err_p0;

  logic              legal;
  logic              in_ready;
  logic              accept;
  logic [N_OUT-1:0]  load;
  logic [N_OUT-1:0]  drain;

  function automatic logic is_onehot(input logic [N_OUT-1:0] s);
    int c;
    c = 0;
    for (int i = 0; i < N_OUT; i++) c += int'(s[i]);
    return (c == 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  // Illegal selects are always consumed so a bad word can never stall the upstream.
  always_comb begin
    legal    = is_onehot(bus.in_sel_i);
    in_ready = legal ? |(bus.in_sel_i & (~vld_p0 | bus.out_ready_i)) : 1'b1;
    accept   = bus.in_valid_i & in_ready;
    load     = (accept && legal) ? bus.in_sel_i : '0;
    drain    = vld_p0 & bus.out_ready_i;
  end

  // Stage p0: per-channel holding registers; a load in the same cycle as a drain keeps valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= '0;
      err_p0 <= 1'b0;
      for (int k = 0; k < N_OUT; k++) data_p0[k] <= '0;
    end else begin
      vld_p0 <= load | (vld_p0 & ~drain);
      err_p0 <= accept & ~legal;
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) data_p0[k] <= bus.in_data_i;
      end
    end
  end

`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_p0 <= '0;
    end else if (accept && !legal) begin
      err_cnt_p0 <= sat_inc(err_cnt_p0);
    end
  end

  assign bus.err_cnt_o = err_cnt_p0;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = vld_p0;
  assign bus.err_o       = err_p0;

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign bus.out_data_o[g*DATA_W +: DATA_W] = data_p0[g];
  end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Scoreboard bench for demux_1_4_stream: per-channel expected-word queues filled on accept, drained on handshake.
// Build with DEMUX_ERR_CNT_EN defined to also cover the saturating error counter.
`timescale 1ns/1ps
module tb_demux_1_4_stream;
  localparam int DW = 4;
  localparam int N  = 4;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  demux_1_4_stream_if #(.DATA_W(DW), .N_OUT(N)) bus ();

  demux_1_4_stream #(.DATA_W(DW), .N_OUT(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] q [N][$];
  logic          err_exp = 1'b0;
  logic [7:0]    cnt_exp = 8'h00;
  logic          m_legal;
  logic          m_rdy;
  int            m_k;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_vld",  bus.out_valid_o, '0);
      check("rst_data", bus.out_data_o,  '0);
      check("rst_err",  bus.err_o,       1'b0);
      for (int k = 0; k < N; k++) q[k].delete();
      err_exp = 1'b0;
      cnt_exp = 8'h00;
    end else begin
      for (int k = 0; k < N; k++) begin
        check("sb_vld", bus.out_valid_o[k], q[k].size() != 0);
        if (q[k].size() != 0) check("sb_data", bus.out_data_o[k*DW +: DW], q[k][0]);
      end
      check("sb_err", bus.err_o, err_exp);
`ifdef DEMUX_ERR_CNT_EN
      check("sb_cnt", bus.err_cnt_o, cnt_exp);
`endif
      m_legal = ($countones(bus.in_sel_i) == 1);
      m_k = 0;
      for (int k = 0; k < N; k++) if (bus.in_sel_i[k]) m_k = k;
      m_rdy = m_legal ? ((q[m_k].size() == 0) || bus.out_ready_i[m_k]) : 1'b1;
      if (bus.in_valid_i) check("sb_in_rdy", bus.in_ready_o, m_rdy);
      for (int k = 0; k < N; k++)
        if (q[k].size() != 0 && bus.out_ready_i[k]) void'(q[k].pop_front());
      err_exp = bus.in_valid_i && !m_legal;
      if (bus.in_valid_i && m_rdy && m_legal) q[m_k].push_back(bus.in_data_i);
      if (err_exp && cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] s, input logic [DW-1:0] d);
    bus.in_valid_i = v;
    bus.in_sel_i   = s;
    bus.in_data_i  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n         = 1'b0;
    bus.out_ready_i = '0;
    drive(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'($urandom), N'($urandom), DW'($urandom));
      bus.out_ready_i = N'($urandom);
    end
    #1;
    check("reset_vld",  bus.out_valid_o, 4'b0000);
    check("reset_data", bus.out_data_o,  16'h0000);
    check("reset_err",  bus.err_o,       1'b0);
    step();
    reset_n = 1'b1;
    drive(1'b0, '0, '0);
    bus.out_ready_i = '0;
    step();
    #1;
    check("idle_vld", bus.out_valid_o, 4'b0000);
    check("idle_err", bus.err_o, 1'b0);

    // Routing to channel 2, then a blocked second word
    drive(1'b1, 4'b0100, 4'hA);
    step();
    drive(1'b1, 4'b0100, 4'hB);
    #1;
    check("route_vld",  bus.out_valid_o, 4'b0100);
    check("route_data", bus.out_data_o[11:8], 4'hA);
    check("route_full_rdy", bus.in_ready_o, 1'b0);
    step();
    drive(1'b0, '0, '0);
    #1;
    check("route_hold", bus.out_data_o[11:8], 4'hA);
    bus.out_ready_i = 4'b0100;
    step();
    bus.out_ready_i = '0;
    #1;
    check("route_drained", bus.out_valid_o, 4'b0000);

    // Back-to-back drain and load on channel 1
    drive(1'b1, 4'b0010, 4'h3);
    step();
    drive(1'b1, 4'b0010, 4'h5);
    bus.out_ready_i = 4'b0010;
    #1;
    check("b2b_rdy", bus.in_ready_o, 1'b1);
    step();
    drive(1'b0, '0, '0);
    bus.out_ready_i = '0;
    #1;
    check("b2b_vld",  bus.out_valid_o, 4'b0010);
    check("b2b_data", bus.out_data_o[7:4], 4'h5);
    bus.out_ready_i = 4'b0010;
    step();
    bus.out_ready_i = '0;

    // Illegal selects
    drive(1'b1, 4'b0000, 4'hC);
    #1;
    check("ill_zero_rdy", bus.in_ready_o, 1'b1);
    step();
    drive(1'b1, 4'b1001, 4'hD);
    #1;
    check("ill_multi_rdy", bus.in_ready_o, 1'b1);
    check("ill_zero_err", bus.err_o, 1'b1);
    step();
    drive(1'b0, '0, '0);
    #1;
    check("ill_multi_err", bus.err_o, 1'b1);
    check("ill_no_vld", bus.out_valid_o, 4'b0000);
    step();
    check("ill_err_clear", bus.err_o, 1'b0);
`ifdef DEMUX_ERR_CNT_EN
    check("ill_cnt2", bus.err_cnt_o, 8'd2);
`endif
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b1111, DW'($urandom));
      step();
    end
    drive(1'b0, '0, '0);
    step();
`ifdef DEMUX_ERR_CNT_EN
    check("ill_cnt_sat", bus.err_cnt_o, 8'hFF);
`endif
    check("ill_sat_no_vld", bus.out_valid_o, 4'b0000);

    // Independence: channel 0 stalled full, channel 3 still accepts
    drive(1'b1, 4'b0001, 4'h1);
    step();
    drive(1'b1, 4'b1000, 4'h7);
    #1;
    check("ind_rdy", bus.in_ready_o, 1'b1);
    step();
    drive(1'b0, '0, '0);
    #1;
    check("ind_vld",   bus.out_valid_o, 4'b1001);
    check("ind_data3", bus.out_data_o[15:12], 4'h7);
    check("ind_data0", bus.out_data_o[3:0], 4'h1);
    bus.out_ready_i = 4'b1111;
    step();
    bus.out_ready_i = '0;

    // Random traffic with random back-pressure
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom),
            ($urandom_range(0, 4) != 0) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom),
            DW'($urandom));
      bus.out_ready_i = N'($urandom);
      step();
    end
    drive(1'b0, '0, '0);
    bus.out_ready_i = 4'b1111;
    step();
    step();
    bus.out_ready_i = '0;

    // Reset while every channel holds a word
    for (int k = 0; k < N; k++) begin
      drive(1'b1, N'(1 << k), DW'(k + 8));
      step();
    end
    drive(1'b0, '0, '0);
    #1;
    check("full_vld", bus.out_valid_o, 4'b1111);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_vld",  bus.out_valid_o, 4'b0000);
    check("async_data", bus.out_data_o,  16'h0000);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_vld", bus.out_valid_o, 4'b0000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
